// File: rtl/led_breather.sv
// Breathing-LED PWM driver: ramps duty up, holds, ramps down, holds, once per synchronised tick.
// Optional macro LED_BREATHER_GAMMA_EN squares the duty before the PWM compare.
module led_breather #(
  parameter int PWM_W          = 8,
  parameter int STEP           = 16,
  parameter int HOLD_TICKS     = 4,
  parameter int LED_ACTIVE_LOW = 0
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             en_in,
  input  logic             tick_in,
  output logic             led_out,
  output logic [PWM_W-1:0] duty_out,
  output logic [2:0]       state_out,
  output logic             cycle_done
);

  localparam int               HOLD_W    = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [PWM_W-1:0] DUTY_MAX  = '1;
  localparam logic [PWM_W-1:0] STEP_V    = PWM_W'(STEP);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);
  localparam logic             LED_POL   = (LED_ACTIVE_LOW != 0);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    HOLD_HIGH = 3'd2,
    RAMP_DOWN = 3'd3,
    HOLD_LOW  = 3'd4
  } state_t;

  state_t             state_q;
  logic [PWM_W-1:0]   duty_q;
  logic [PWM_W-1:0]   pwm_cnt_q;
  logic [PWM_W-1:0]   duty_eff;
  logic [HOLD_W-1:0]  hold_cnt_q;
  logic               sync1_q, sync2_q, sync3_q;
  logic               step;
  logic               cycle_done_q;
  logic               led_q;

  // Two flops resynchronise tick_in; the third gives a one-clock rising-edge pulse.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= tick_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign step = sync2_q & ~sync3_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      duty_q       <= '0;
      hold_cnt_q   <= '0;
      cycle_done_q <= 1'b0;
    end else begin
      cycle_done_q <= 1'b0;
      if (!en_in) begin
        state_q    <= IDLE;
        duty_q     <= '0;
        hold_cnt_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            duty_q     <= '0;
            hold_cnt_q <= '0;
            state_q    <= RAMP_UP;
          end
          RAMP_UP: if (step) begin
            // Saturate at full brightness rather than let the add wrap.
            if (duty_q >= DUTY_MAX - STEP_V) begin
              duty_q     <= DUTY_MAX;
              hold_cnt_q <= '0;
              state_q    <= HOLD_HIGH;
            end else begin
              duty_q <= duty_q + STEP_V;
            end
          end
          HOLD_HIGH: if (step) begin
            if (hold_cnt_q == HOLD_LAST) begin
              hold_cnt_q <= '0;
              state_q    <= RAMP_DOWN;
            end else begin
              hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
            end
          end
          RAMP_DOWN: if (step) begin
            if (duty_q <= STEP_V) begin
              duty_q     <= '0;
              hold_cnt_q <= '0;
              state_q    <= HOLD_LOW;
            end else begin
              duty_q <= duty_q - STEP_V;
            end
          end
          HOLD_LOW: if (step) begin
            if (hold_cnt_q == HOLD_LAST) begin
              hold_cnt_q   <= '0;
              state_q      <= RAMP_UP;
              cycle_done_q <= 1'b1;
            end else begin
              hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
            end
          end
          default: begin
            state_q    <= IDLE;
            duty_q     <= '0;
            hold_cnt_q <= '0;
          end
        endcase
      end
    end
  end

`ifdef LED_BREATHER_GAMMA_EN
  // Squaring approximates a perceptual gamma curve; keep the upper half of the product.
  logic [2*PWM_W-1:0] duty_wide;
  logic [2*PWM_W-1:0] duty_sq;
  assign duty_wide = {{PWM_W{1'b0}}, duty_q};
  assign duty_sq   = duty_wide * duty_wide;
  assign duty_eff  = duty_sq[2*PWM_W-1:PWM_W];
`else
  assign duty_eff = duty_q;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pwm_cnt_q <= '0;
      led_q     <= LED_POL;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + PWM_W'(1);
      led_q     <= (pwm_cnt_q < duty_eff) ^ LED_POL;
    end
  end

  assign led_out    = led_q;
  assign duty_out   = duty_q;
  assign state_out  = state_q;
  assign cycle_done = cycle_done_q;

endmodule

// File: tb/tb_led_breather.sv
// Directed bench for led_breather (PWM_W=8, STEP=64, HOLD_TICKS=2, active-high LED).
// Expected PWM on-counts follow LED_BREATHER_GAMMA_EN when the bench is built with it.
module tb_led_breather;

  logic       clk_in;
  logic       rst_in;
  logic       en_in;
  logic       tick_in;
  logic       led_out;
  logic [7:0] duty_out;
  logic [2:0] state_out;
  logic       cycle_done;

  int checks = 0;
  int errors = 0;
  int cdPulses;
  int highCount;

`ifdef LED_BREATHER_GAMMA_EN
  localparam int EXP_ON_64  = 16;
  localparam int EXP_ON_128 = 64;
  localparam int EXP_ON_255 = 254;
`else
  localparam int EXP_ON_64  = 64;
  localparam int EXP_ON_128 = 128;
  localparam int EXP_ON_255 = 255;
`endif

  led_breather #(
    .PWM_W(8),
    .STEP(64),
    .HOLD_TICKS(2),
    .LED_ACTIVE_LOW(0)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .en_in(en_in),
    .tick_in(tick_in),
    .led_out(led_out),
    .duty_out(duty_out),
    .state_out(state_out),
    .cycle_done(cycle_done)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // One full tick_in pulse; counts cycle_done pulses seen along the way.
  task automatic applyStimulus(output int pulses);
    pulses = 0;
    tick_in = 1'b1;
    repeat (4) begin
      @(posedge clk_in); #1;
      if (cycle_done === 1'b1) pulses++;
    end
    tick_in = 1'b0;
    repeat (4) begin
      @(posedge clk_in); #1;
      if (cycle_done === 1'b1) pulses++;
    end
  endtask

  task automatic countHigh(output int n);
    n = 0;
    repeat (256) begin
      @(negedge clk_in);
      if (led_out === 1'b1) n++;
    end
  endtask

  initial begin
    rst_in  = 1'b1;
    en_in   = 1'b0;
    tick_in = 1'b0;

    repeat (4) begin
      @(posedge clk_in); #1;
      tick_in = ~tick_in;
    end
    checkOutput("reset_led", led_out, 0);
    checkOutput("reset_duty", duty_out, 0);
    checkOutput("reset_state", state_out, 0);
    checkOutput("reset_cycle_done", cycle_done, 0);

    tick_in = 1'b0;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    repeat (4) @(posedge clk_in);
    #1;
    checkOutput("idle_state", state_out, 0);
    countHigh(highCount);
    checkOutput("pwm_on_duty0", highCount, 0);

    $display("[TB] enabling and ramping up");
    @(posedge clk_in); #1;
    en_in = 1'b1;
    @(posedge clk_in); #1;
    checkOutput("enable_state", state_out, 1);
    checkOutput("enable_duty", duty_out, 0);

    applyStimulus(cdPulses);
    checkOutput("ramp1_duty", duty_out, 64);
    countHigh(highCount);
    checkOutput("pwm_on_duty64", highCount, EXP_ON_64);

    applyStimulus(cdPulses);
    checkOutput("ramp2_duty", duty_out, 128);
    countHigh(highCount);
    checkOutput("pwm_on_duty128", highCount, EXP_ON_128);

    applyStimulus(cdPulses);
    checkOutput("ramp3_duty", duty_out, 192);
    applyStimulus(cdPulses);
    checkOutput("ramp4_duty", duty_out, 255);
    checkOutput("ramp4_state", state_out, 2);
    countHigh(highCount);
    checkOutput("pwm_on_duty255", highCount, EXP_ON_255);

    $display("[TB] hold high, ramp down, hold low");
    applyStimulus(cdPulses);
    checkOutput("hold_high1_state", state_out, 2);
    applyStimulus(cdPulses);
    checkOutput("hold_high2_state", state_out, 3);
    checkOutput("hold_high2_duty", duty_out, 255);
    applyStimulus(cdPulses);
    checkOutput("down1_duty", duty_out, 191);
    applyStimulus(cdPulses);
    checkOutput("down2_duty", duty_out, 127);
    applyStimulus(cdPulses);
    checkOutput("down3_duty", duty_out, 63);
    applyStimulus(cdPulses);
    checkOutput("down4_duty", duty_out, 0);
    checkOutput("down4_state", state_out, 4);
    applyStimulus(cdPulses);
    checkOutput("hold_low1_state", state_out, 4);
    checkOutput("hold_low1_pulses", cdPulses, 0);
    applyStimulus(cdPulses);
    checkOutput("hold_low2_pulses", cdPulses, 1);
    checkOutput("hold_low2_state", state_out, 1);
    checkOutput("hold_low2_duty", duty_out, 0);

    $display("[TB] abort mid ramp with coincident step");
    applyStimulus(cdPulses);
    applyStimulus(cdPulses);
    checkOutput("pre_abort_duty", duty_out, 128);
    tick_in = 1'b1;
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    en_in = 1'b0;
    @(posedge clk_in); #1;
    checkOutput("abort_state", state_out, 0);
    checkOutput("abort_duty", duty_out, 0);
    checkOutput("abort_cycle_done", cycle_done, 0);

    $display("[TB] tick held high for 1000 clocks");
    tick_in = 1'b0;
    repeat (4) @(posedge clk_in);
    #1;
    en_in = 1'b1;
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    tick_in = 1'b1;
    repeat (1000) @(posedge clk_in);
    #1;
    checkOutput("held_tick_duty", duty_out, 64);
    checkOutput("held_tick_state", state_out, 1);

    rst_in = 1'b1;
    @(posedge clk_in); #1;
    checkOutput("midramp_reset_duty", duty_out, 0);
    checkOutput("midramp_reset_state", state_out, 0);
    rst_in  = 1'b0;
    tick_in = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
